// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding and BCD limits.
package stopwatch_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Next BCD value of a single decade, wrapping 9 -> 0.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One decade stage of the stopwatch carry chain; ten pulses when this stage wraps.
module bcd_digit
  import stopwatch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] count,
  output logic       ten
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 4'd0;
    end else if (en) begin
      count_d = bcd_inc(count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign ten   = en && (count_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear stopwatch: prescaler tick, DIGITS-stage BCD carry chain, lap latch, sticky overflow.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic                  running,
  output logic                  tick,
  output logic [4*DIGITS-1:0]   digits,
  output logic [4*DIGITS-1:0]   lap_digits,
  output logic                  lap_valid,
  output logic                  overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  // Commands are single-cycle pulses sampled on every edge; there is no
  // handshake, so a command not legal in the current state is simply dropped.
  state_t                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  overflow_q, overflow_d;
  logic [4*DIGITS-1:0]   lap_digits_q, lap_digits_d;
  logic                  lap_valid_q, lap_valid_d;
  logic [DIGITS:0]       en;
  logic                  lap_take;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; clear dominates, start&stop together cancel out
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (start && !stop) begin
      if (state_q != ST_RUN) state_d = ST_RUN;
    end else if (stop && !start) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end
  end

  // FSM: outputs decoded from the registered state
  always_comb begin
    running = (state_q == ST_RUN);
    tick    = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
  end

  // Prescaler holds in PAUSE so that a resume keeps the tick phase.
  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end
  end

  assign en[0] = tick;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .en    (en[i]),
      .count (digits[4*i +: 4]),
      .ten   (en[i+1])
    );
  end

  always_comb begin
    overflow_d = clear ? 1'b0 : (overflow_q | en[DIGITS]);
  end

  // Lap captures the count as seen this cycle, before any same-edge increment.
  always_comb begin
    lap_take     = lap && !clear && ((state_q == ST_RUN) || (state_q == ST_PAUSE));
    lap_digits_d = lap_take ? digits : lap_digits_q;
    lap_valid_d  = lap_take;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      overflow_q   <= 1'b0;
      lap_digits_q <= '0;
      lap_valid_q  <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      overflow_q   <= overflow_d;
      lap_digits_q <= lap_digits_d;
      lap_valid_q  <= lap_valid_d;
    end
  end

  assign overflow   = overflow_q;
  assign lap_digits = lap_digits_q;
  assign lap_valid  = lap_valid_q;

endmodule
